pakout_arbiter: RTL and testbench
=================================

Name: pakout_arbiter

Overview:
Round-robin arbiter that shares one outgoing packet link among NUM_SRC packet sources.
It sits between several pakout-style producers and a single consumer link, such as a pakout_io sink.
It accepts one packet at a time from the granted source, forwards it over a 4-phase req/ack handshake, and acknowledges the source only after the consumer has taken the packet.
It also exposes the current grant, busy status and a packet count for the debug display path.

Parameters:
PSZ, `NS_PACKET_SIZE, packet width in bits.
NUM_SRC, 4, number of requesting sources (2..16).
IDX_SZ, 2, width of grant index; must satisfy 2^IDX_SZ >= NUM_SRC.
CNT_SZ, 16, width of forwarded-packet counter.

Ports:
i_clk  input  1  single clock; all inputs synchronous to it.
reset  input  1  asynchronous, active-high reset.
ready  output  1  block initialised and accepting requests.
rcv_req  input  NUM_SRC  per-source request; bit i belongs to source i.
rcv_ack  output  NUM_SRC  per-source acknowledge.
rcv_data  input  NUM_SRC*PSZ  per-source packet; source i occupies [i*PSZ +: PSZ]; stable while rcv_req[i]=1.
snd_req  output  1  outgoing request.
snd_ack  input  1  outgoing acknowledge from consumer.
snd_data  output  PSZ  outgoing packet; registered, stable while snd_req=1.
grant_idx  output  IDX_SZ  index of last/current granted source.
busy  output  1  transfer in progress (state != IDLE).
pak_cnt  output  CNT_SZ  number of completed transfers.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0: ready, rcv_ack, snd_req, snd_data, busy, pak_cnt.
  - grant_idx = NUM_SRC-1, so source 0 has first priority.
  - state = IDLE.
- ready: goes to 1 on the first i_clk edge after reset is released and stays 1.
  - No request is granted while ready=0.
- Handshake protocol, both sides, 4-phase:
  - req rises → ack rises → req falls → ack falls.
- FSM states: IDLE, SEND, SND_REL, SRC_ACK, SRC_REL.
  - IDLE:
    - If ready and any rcv_req bit is set, select the winner g.
    - Search order: (grant_idx+1) mod NUM_SRC upward, wrapping.
    - On that edge: snd_data <= rcv_data[g], grant_idx <= g, snd_req <= 1, busy <= 1 → SEND.
    - Latency: rcv_req seen high at edge t gives snd_req=1 after edge t.
  - SEND: wait for snd_ack=1; then snd_req <= 0 → SND_REL.
  - SND_REL: wait for snd_ack=0; then rcv_ack[g] <= 1 and pak_cnt <= pak_cnt+1 (wraps modulo 2^CNT_SZ) → SRC_ACK.
  - SRC_ACK: wait for rcv_req[g]=0; then rcv_ack[g] <= 0 → SRC_REL.
  - SRC_REL: one cycle; busy <= 0 → IDLE.
    - This cycle guarantees the source sees ack low before re-arbitration.
- At most one rcv_ack bit is ever high.
- Requests from non-granted sources are held pending and never acknowledged out of turn.
- Simultaneous requests: exactly one is granted, chosen by round-robin order.
  - A source that keeps re-requesting cannot starve the others.
- Request withdrawn before grant (rcv_req drops while in IDLE): ignored, nothing forwarded.
- Request dropped by the granted source during SEND or SND_REL is a protocol violation.
  - The FSM still completes the outgoing transfer, then raises rcv_ack[g].
  - SRC_ACK exits immediately because rcv_req[g]=0.
- snd_ack high while in IDLE is ignored.
- snd_data is only updated on a grant, never while snd_req=1.
- Reset asserted mid-transfer: immediate return to reset values; in-flight packet is dropped and not counted.
- Minimum transfer: 5 cycles plus consumer and source response delays.

Test Plan:
- Reset/ready: hold reset 3 cycles with rcv_req=4'b0001 → snd_req=0, ready=0 during reset; ready=1 one edge after release; snd_req=1 on the following edge with snd_data=src0 packet, grant_idx=0.
- Single transfer: src2 sends 0xA5 with a consumer acking after 2 cycles → snd_data=0xA5, rcv_ack=4'b0100 only after snd_ack has fallen, pak_cnt=1, busy returns 0.
- Round-robin fairness: all four sources request continuously, 8 packets → grant order 0,1,2,3,0,1,2,3; pak_cnt=8; never two rcv_ack bits high.
- Rotation from last grant: last grant=1, then rcv_req=4'b1001 → source 3 granted before source 0.
- Counter wrap: CNT_SZ=4, 17 transfers → pak_cnt=1.
- Async reset mid-SEND: assert reset while snd_req=1 → snd_req, rcv_ack and busy go 0 without a clock edge; pak_cnt=0; after release, the pending source is re-served from source 0 priority.

Source files
------------

// File: rtl/pakout_arbiter.sv
// Round-robin arbiter sharing one outgoing 4-phase packet link among NUM_SRC sources.
// A source is acknowledged only after the consumer has fully taken its packet.
`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 8
`endif

module pakout_arbiter #(
    parameter int PSZ     = `NS_PACKET_SIZE,
    parameter int NUM_SRC = 4,
    parameter int IDX_SZ  = 2,
    parameter int CNT_SZ  = 16
) (
    input  logic                   i_clk,
    input  logic                   reset,
    output logic                   ready,
    input  logic [NUM_SRC-1:0]     rcv_req,
    output logic [NUM_SRC-1:0]     rcv_ack,
    input  logic [NUM_SRC*PSZ-1:0] rcv_data,
    output logic                   snd_req,
    input  logic                   snd_ack,
    output logic [PSZ-1:0]         snd_data,
    output logic [IDX_SZ-1:0]      grant_idx,
    output logic                   busy,
    output logic [CNT_SZ-1:0]      pak_cnt
);

    localparam int NSLOT = 1 << IDX_SZ;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        SND_REL,
        SRC_ACK,
        SRC_REL
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [NUM_SRC-1:0]  rcv_ack_q, rcv_ack_d;
    logic                snd_req_q, snd_req_d;
    logic [PSZ-1:0]      snd_data_q, snd_data_d;
    logic [IDX_SZ-1:0]   grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [CNT_SZ-1:0]   cnt_q, cnt_d;

    // Requests and data padded to a power-of-two slot count so any grant index is in range.
    logic [NSLOT-1:0]    req_ext;
    logic [PSZ-1:0]      data_slot [NSLOT];
    logic [NSLOT-1:0]    ack_onehot;

    assign req_ext    = NSLOT'(rcv_req);
    assign ack_onehot = NSLOT'(1) << grant_q;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NUM_SRC) begin : g_src
            assign data_slot[gi] = rcv_data[gi*PSZ +: PSZ];
        end else begin : g_pad
            assign data_slot[gi] = '0;
        end
    end

    logic                win_found;
    logic [IDX_SZ-1:0]   win_idx;
    logic [IDX_SZ:0]     cand;

    // Search starts just after the last grant and wraps, giving round-robin fairness.
    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, grant_q} + (IDX_SZ+1)'(k);
            if (cand >= (IDX_SZ+1)'(NUM_SRC)) begin
                cand = cand - (IDX_SZ+1)'(NUM_SRC);
            end
            if (!win_found && req_ext[cand[IDX_SZ-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_SZ-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b1;
        rcv_ack_d  = rcv_ack_q;
        snd_req_d  = snd_req_q;
        snd_data_d = snd_data_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (ready_q && win_found) begin
                    snd_data_d = data_slot[win_idx];
                    grant_d    = win_idx;
                    snd_req_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (snd_ack) begin
                    snd_req_d = 1'b0;
                    state_d   = SND_REL;
                end
            end
            SND_REL: begin
                if (!snd_ack) begin
                    rcv_ack_d = ack_onehot[NUM_SRC-1:0];
                    cnt_d     = cnt_q + CNT_SZ'(1);
                    state_d   = SRC_ACK;
                end
            end
            SRC_ACK: begin
                if (!req_ext[grant_q]) begin
                    rcv_ack_d = '0;
                    state_d   = SRC_REL;
                end
            end
            SRC_REL: begin
                // Extra cycle so the source sees its ack low before re-arbitration.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            rcv_ack_q  <= '0;
            snd_req_q  <= 1'b0;
            snd_data_q <= '0;
            grant_q    <= IDX_SZ'(NUM_SRC - 1);
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rcv_ack_q  <= rcv_ack_d;
            snd_req_q  <= snd_req_d;
            snd_data_q <= snd_data_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ready     = ready_q;
    assign rcv_ack   = rcv_ack_q;
    assign snd_req   = snd_req_q;
    assign snd_data  = snd_data_q;
    assign grant_idx = grant_q;
    assign busy      = busy_q;
    assign pak_cnt   = cnt_q;

endmodule

// File: tb/tb_pakout_arbiter.sv
// Bench for pakout_arbiter: protocol-level model checked every cycle, plus directed
// scenarios with hand-computed grant orders, counts and reset behaviour.
module tb_pakout_arbiter;

    localparam int PSZ = 8;
    localparam int NS  = 4;
    localparam int IW  = 2;
    localparam int CW  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           ready;
    logic [NS-1:0]  rcv_req = '0;
    logic [NS-1:0]  rcv_ack;
    logic [NS*PSZ-1:0] rcv_data = '0;
    logic           snd_req;
    logic           snd_ack = 1'b0;
    logic [PSZ-1:0] snd_data;
    logic [IW-1:0]  grant_idx;
    logic           busy;
    logic [CW-1:0]  pak_cnt;

    always #5 clk = ~clk;

    pakout_arbiter #(.PSZ(PSZ), .NUM_SRC(NS), .IDX_SZ(IW), .CNT_SZ(CW)) dut (
        .i_clk(clk), .reset(reset), .ready(ready),
        .rcv_req(rcv_req), .rcv_ack(rcv_ack), .rcv_data(rcv_data),
        .snd_req(snd_req), .snd_ack(snd_ack), .snd_data(snd_data),
        .grant_idx(grant_idx), .busy(busy), .pak_cnt(pak_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source and consumer agents
    int             remaining [NS];
    logic [PSZ-1:0] pkt_val   [NS];
    logic [PSZ-1:0] src_data  [NS];
    int             cdelay = 2;
    int             ccnt = 0;

    initial begin
        for (int i = 0; i < NS; i++) begin
            remaining[i] = 0;
            pkt_val[i]   = 8'(8'h10 * (i + 1));
            src_data[i]  = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (rcv_req[i] && rcv_ack[i]) begin
                    rcv_req[i] = 1'b0;
                    remaining[i]--;
                    pkt_val[i]++;
                end else if (!rcv_req[i] && !rcv_ack[i] && remaining[i] > 0) begin
                    rcv_req[i]  = 1'b1;
                    src_data[i] = pkt_val[i];
                end
            end
            rcv_data = {src_data[3], src_data[2], src_data[1], src_data[0]};
            if (!snd_req) begin
                snd_ack = 1'b0;
                ccnt    = 0;
            end else if (!snd_ack) begin
                if (ccnt >= cdelay) snd_ack = 1'b1;
                else ccnt++;
            end
        end
    end

    // Protocol model: inputs seen at each rising edge, outputs compared on the falling edge
    logic [NS-1:0]     req_e;
    logic              sack_e;
    logic              rst_e;
    logic [NS*PSZ-1:0] data_e;

    always @(posedge clk) begin
        req_e  <= rcv_req;
        sack_e <= snd_ack;
        rst_e  <= reset;
        data_e <= rcv_data;
    end

    int             m_phase = 0;
    int             m_last  = NS - 1;
    int             m_cnt   = 0;
    bit             m_rdy   = 1'b0;
    logic [PSZ-1:0] m_data  = '0;
    logic           snd_req_prev = 1'b0;
    int             glog[$];

    function automatic int rr_pick(input int last, input logic [NS-1:0] req);
        for (int k = 1; k <= NS; k++) begin
            int c;
            c = (last + k) % NS;
            if (req[c]) return c;
        end
        return last;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_phase = 0; m_last = NS - 1; m_cnt = 0; m_rdy = 1'b0; m_data = '0;
        end else if (!rst_e) begin
            case (m_phase)
                0: if (m_rdy && req_e != 0) begin
                    m_last  = rr_pick(m_last, req_e);
                    m_data  = data_e[m_last*PSZ +: PSZ];
                    m_phase = 1;
                end
                1: if (sack_e) m_phase = 2;
                2: if (!sack_e) begin
                    m_cnt   = (m_cnt + 1) % (1 << CW);
                    m_phase = 3;
                end
                3: if (!req_e[m_last]) m_phase = 4;
                default: m_phase = 0;
            endcase
            m_rdy = 1'b1;
        end
        chk("ready",     ready,     m_rdy);
        chk("snd_req",   snd_req,   m_phase == 1);
        chk("rcv_ack",   rcv_ack,   (m_phase == 3) ? (1 << m_last) : 0);
        chk("busy",      busy,      m_phase != 0);
        chk("grant_idx", grant_idx, m_last);
        chk("pak_cnt",   pak_cnt,   m_cnt);
        chk("snd_data",  snd_data,  m_data);
        chk("ack_onehot", $countones(rcv_ack) <= 1, 1);
        if (snd_req && !snd_req_prev) glog.push_back(int'(grant_idx));
        snd_req_prev = snd_req;
    end

    // kind 0: snd_req high, 1: any rcv_ack high, 2: all sources done and arbiter idle
    task automatic wait_kind(input string name, input int kind);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            case (kind)
                0: ok = snd_req;
                1: ok = (rcv_ack != 0);
                default: ok = (remaining[0] == 0 && remaining[1] == 0 && remaining[2] == 0 &&
                               remaining[3] == 0 && rcv_req == 0 && !busy);
            endcase
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout %s at %0t", name, $time);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Reset / ready with source 0 already requesting
        remaining[0] = 1;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_snd_req", snd_req, 0);
        chk("rst_grant", grant_idx, 3);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rdy_after_release", ready, 1);
        chk("no_grant_before_ready", snd_req, 0);
        @(negedge clk);
        chk("first_snd_req", snd_req, 1);
        chk("first_grant", grant_idx, 0);
        chk("first_data", snd_data, 8'h10);
        wait_kind("t1_idle", 2);
        chk("t1_cnt", pak_cnt, 1);

        // Single transfer from source 2
        pkt_val[2]   = 8'hA5;
        remaining[2] = 1;
        wait_kind("t2_req", 0);
        chk("t2_data", snd_data, 8'hA5);
        chk("t2_grant", grant_idx, 2);
        wait_kind("t2_ack", 1);
        chk("t2_rcv_ack", rcv_ack, 4'b0100);
        chk("t2_snd_ack_low", snd_ack, 0);
        chk("t2_snd_req_low", snd_req, 0);
        wait_kind("t2_idle", 2);
        chk("t2_cnt", pak_cnt, 2);
        chk("t2_busy", busy, 0);

        // Fairness: all four request twice from a fresh reset
        pulse_reset();
        glog.delete();
        for (int i = 0; i < NS; i++) remaining[i] = 2;
        wait_kind("t3_idle", 2);
        chk("t3_grants", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) chk("t3_rr_order", glog[k], k % 4);
        chk("t3_cnt", pak_cnt, 8);

        // Rotation from last grant 1 with requests 4'b1001
        glog.delete();
        remaining[1] = 1;
        wait_kind("t4a_idle", 2);
        remaining[0] = 1;
        remaining[3] = 1;
        wait_kind("t4b_idle", 2);
        chk("t4_grants", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t4_g0", glog[0], 1);
            chk("t4_g1", glog[1], 3);
            chk("t4_g2", glog[2], 0);
        end
        chk("t4_cnt", pak_cnt, 11);

        // Counter wrap: 17 transfers on a 4-bit counter
        pulse_reset();
        remaining[1] = 9;
        remaining[2] = 8;
        wait_kind("t5_idle", 2);
        chk("t5_cnt_wrap", pak_cnt, 1);

        // Asynchronous reset while source 2 is in SEND
        remaining[2] = 1;
        wait_kind("t6_req", 0);
        chk("t6_grant", grant_idx, 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_snd_req", snd_req, 0);
        chk("t6_async_rcv_ack", rcv_ack, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_cnt", pak_cnt, 0);
        chk("t6_async_grant", grant_idx, 3);
        remaining[1] = 1;
        glog.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_kind("t6_idle", 2);
        chk("t6_grants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t6_g0", glog[0], 1);
            chk("t6_g1", glog[1], 2);
        end
        chk("t6_cnt", pak_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
